// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch PC owner and single-outstanding imem request sequencer
module pc_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_i_valid,
  input  logic [63:0]       trap_i_pc,
  input  logic              execute_i_is_jump,
  input  logic [63:0]       execute_i_pre_pc,
  input  logic [63:0]       fetch_i_pre_pc,
  output logic              imem_req_valid,
  output logic [63:0]       imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              if_o_valid,
  output logic [63:0]       if_o_pc,
  output logic [INST_W-1:0] if_o_inst,
  input  logic              if_o_ready,
  output logic [63:0]       pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t              state, state_nxt;
  logic [63:0]         pc_nxt, ipc_nxt, target;
  logic [INST_W-1:0]   inst_nxt;
  logic                valid_nxt, req_nxt, redir, req_hs;

  // Trap outranks the execute-stage redirect when both fire together.
  assign redir         = trap_i_valid | execute_i_is_jump;
  assign target        = trap_i_valid ? trap_i_pc : execute_i_pre_pc;
  assign req_hs        = imem_req_valid & imem_req_ready;
  assign imem_req_addr = pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = if_o_valid;
    ipc_nxt   = if_o_pc;
    inst_nxt  = if_o_inst;
    case (state)
      S_REQ: begin
        if (redir) pc_nxt = target;
        if (req_hs) state_nxt = redir ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (redir) begin
            pc_nxt    = target;
            state_nxt = S_REQ;
          end else begin
            ipc_nxt   = pc;
            inst_nxt  = imem_rsp_data;
            valid_nxt = 1'b1;
            state_nxt = S_HOLD;
          end
        end else if (redir) begin
          pc_nxt    = target;
          state_nxt = S_DROP;
        end
      end
      S_HOLD: begin
        if (redir) begin
          pc_nxt    = target;
          valid_nxt = 1'b0;
          state_nxt = S_REQ;
        end else if (if_o_ready) begin
          pc_nxt    = fetch_i_pre_pc;
          valid_nxt = 1'b0;
          state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        // The one response still in flight belongs to a dead path.
        if (redir) pc_nxt = target;
        if (imem_rsp_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
    req_nxt = (state_nxt == S_REQ);
  end

  // Request valid is its own flop so it stays low throughout reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      imem_req_valid <= 1'b0;
      if_o_valid     <= 1'b0;
      if_o_pc        <= '0;
      if_o_inst      <= '0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      imem_req_valid <= req_nxt;
      if_o_valid     <= valid_nxt;
      if_o_pc        <= ipc_nxt;
      if_o_inst      <= inst_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trap_i_valid = 1'b0, execute_i_is_jump = 1'b0;
  logic [63:0] trap_i_pc = '0, execute_i_pre_pc = '0, fetch_i_pre_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr, if_o_pc, pc;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0, if_o_inst;
  logic        if_o_valid, if_o_ready = 1'b0;

  pc_fetch_ctrl #(.RESET_PC(RPC), .INST_W(32)) dut (
    .clk(clk), .rst(rst),
    .trap_i_valid(trap_i_valid), .trap_i_pc(trap_i_pc),
    .execute_i_is_jump(execute_i_is_jump), .execute_i_pre_pc(execute_i_pre_pc),
    .fetch_i_pre_pc(fetch_i_pre_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_o_valid(if_o_valid), .if_o_pc(if_o_pc), .if_o_inst(if_o_inst),
    .if_o_ready(if_o_ready), .pc(pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: fetch PC plus flags for "request in flight",
  // "that in-flight response is stale" and "instruction being presented".
  logic [63:0] m_pc, m_hpc;
  logic [31:0] m_hinst;
  logic        m_started, m_out, m_stale, m_held, m_acc;

  // Imem responder used in the random phase.
  logic        pend;
  int          delay;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_req();
    return m_started && !m_out && !m_held;
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_hpc = '0; m_hinst = '0;
    m_started = 0; m_out = 0; m_stale = 0; m_held = 0; m_acc = 0;
    pend = 0; delay = 0;
  endtask

  task automatic model_update();
    logic        rd;
    logic [63:0] tgt;
    rd    = trap_i_valid | execute_i_is_jump;
    tgt   = trap_i_valid ? trap_i_pc : execute_i_pre_pc;
    m_acc = exp_req() & imem_req_ready;
    if (m_held) begin
      if (rd) begin m_held = 0; m_pc = tgt; end
      else if (if_o_ready) begin m_held = 0; m_pc = fetch_i_pre_pc; end
    end else if (m_out) begin
      if (imem_rsp_valid) begin
        m_out = 0;
        if (!m_stale && !rd) begin m_held = 1; m_hpc = m_pc; m_hinst = imem_rsp_data; end
        else if (rd) m_pc = tgt;
        m_stale = 0;
      end else if (rd) begin
        m_stale = 1; m_pc = tgt;
      end
    end else begin
      if (rd) m_pc = tgt;
      if (m_acc) begin m_out = 1; m_stale = rd; end
    end
    m_started = 1;
  endtask

  task automatic compare_model();
    chk("req_valid", {63'b0, imem_req_valid}, {63'b0, exp_req()});
    chk("req_addr", imem_req_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("if_valid", {63'b0, if_o_valid}, {63'b0, m_held});
    if (m_held) begin
      chk("if_pc", if_o_pc, m_hpc);
      chk("if_inst", {32'b0, if_o_inst}, {32'b0, m_hinst});
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle_inputs();
    trap_i_valid = 0; execute_i_is_jump = 0; imem_rsp_valid = 0;
    imem_req_ready = 0; if_o_ready = 0;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    model_reset();
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_if_valid", {63'b0, if_o_valid}, 64'd0);
    chk("rst_if_pc", if_o_pc, 64'd0);
    chk("rst_if_inst", {32'b0, if_o_inst}, 64'd0);
    rst = 1;
    step();
    chk("first_req", {63'b0, imem_req_valid}, 64'd1);
    chk("first_addr", imem_req_addr, 64'h8000_0000);

    // Basic fetch then sequential next request.
    imem_req_ready = 1; fetch_i_pre_pc = 64'h8000_0004; if_o_ready = 1;
    step();
    imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0013;
    step();
    imem_rsp_valid = 0;
    chk("fetch_valid", {63'b0, if_o_valid}, 64'd1);
    chk("fetch_pc", if_o_pc, 64'h8000_0000);
    chk("fetch_inst", {32'b0, if_o_inst}, 64'h13);
    chk("model_pin_hpc", m_hpc, 64'h8000_0000);
    step();
    chk("second_addr", imem_req_addr, 64'h8000_0004);
    chk("second_req", {63'b0, imem_req_valid}, 64'd1);

    // Stall in HOLD for three cycles.
    if_o_ready = 0;
    step();
    imem_rsp_valid = 1; imem_rsp_data = 32'h0010_0093;
    step();
    imem_rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", {63'b0, if_o_valid}, 64'd1);
      chk("stall_pc", if_o_pc, 64'h8000_0004);
      chk("stall_noreq", {63'b0, imem_req_valid}, 64'd0);
    end
    if_o_ready = 1; fetch_i_pre_pc = 64'h8000_0008;
    step();
    chk("after_stall_addr", imem_req_addr, 64'h8000_0008);
    chk("after_stall_req", {63'b0, imem_req_valid}, 64'd1);

    // Jump while waiting; late response must be dropped.
    step();
    imem_req_ready = 0;
    execute_i_is_jump = 1; execute_i_pre_pc = 64'h8000_1000;
    step();
    execute_i_is_jump = 0;
    imem_rsp_valid = 1; imem_rsp_data = 32'hdead_beef;
    step();
    imem_rsp_valid = 0;
    chk("drop_if_valid", {63'b0, if_o_valid}, 64'd0);
    chk("jump_addr", imem_req_addr, 64'h8000_1000);
    chk("jump_req", {63'b0, imem_req_valid}, 64'd1);

    // Trap and jump together in HOLD: trap wins.
    imem_req_ready = 1; if_o_ready = 0;
    step();
    imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0013;
    step();
    imem_rsp_valid = 0;
    trap_i_valid = 1; trap_i_pc = 64'h8000_0100;
    execute_i_is_jump = 1; execute_i_pre_pc = 64'h8000_2000;
    step();
    trap_i_valid = 0; execute_i_is_jump = 0;
    chk("trap_kill", {63'b0, if_o_valid}, 64'd0);
    chk("trap_addr", imem_req_addr, 64'h8000_0100);

    // Redirect coincident with response in WAIT: no DROP.
    step();
    imem_rsp_valid = 1; imem_rsp_data = 32'h1111_1111;
    execute_i_is_jump = 1; execute_i_pre_pc = 64'h8000_3000;
    step();
    imem_rsp_valid = 0; execute_i_is_jump = 0;
    chk("coinc_req", {63'b0, imem_req_valid}, 64'd1);
    chk("coinc_addr", imem_req_addr, 64'h8000_3000);
    chk("coinc_if_valid", {63'b0, if_o_valid}, 64'd0);

    // Asynchronous reset mid-WAIT.
    step();
    imem_req_ready = 0;
    #2 rst = 0;
    #1;
    chk("arst_pc", pc, RPC);
    chk("arst_if_valid", {63'b0, if_o_valid}, 64'd0);
    chk("arst_req", {63'b0, imem_req_valid}, 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    step();
    chk("arst_first_addr", imem_req_addr, 64'h8000_0000);
    chk("arst_first_req", {63'b0, imem_req_valid}, 64'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      trap_i_valid      = ($urandom_range(0, 9) == 0);
      trap_i_pc         = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : rand64();
      execute_i_is_jump = ($urandom_range(0, 7) == 0);
      execute_i_pre_pc  = rand64();
      fetch_i_pre_pc    = ($urandom_range(0, 3) == 0) ? rand64() : m_hpc + 64'd4;
      imem_req_ready    = ($urandom_range(0, 3) != 0);
      if_o_ready        = ($urandom_range(0, 1) == 1);
      imem_rsp_data     = $urandom;
      if (pend && delay == 0) begin
        imem_rsp_valid = 1; pend = 0;
      end else begin
        if (pend) delay--;
        // Occasional spurious response while nothing is outstanding.
        imem_rsp_valid = !pend && !m_out && ($urandom_range(0, 15) == 0);
      end
      step();
      if (m_acc) begin pend = 1; delay = $urandom_range(0, 2); end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
